// File: rtl/mole_scheduler_pkg.sv
// Shared types and constants for the whack-a-mole scheduler.
// Used by mole_scheduler and mole_lfsr.
package mole_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_OVER
  } state_e;

  localparam int          NUM_HOLES = 9;
  localparam logic [3:0]  NO_HIT    = 4'hF;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  function automatic logic [3:0] popcnt9(
    input logic [NUM_HOLES-1:0] m
  );
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < NUM_HOLES; i++) begin
      c = c + {3'b000, m[i]};
    end
    return c;
  endfunction

  function automatic logic [7:0] sat_inc(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, free-running.
// Feeds the mole spawn candidate.
module mole_lfsr
  import mole_scheduler_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] value
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        fb;

  always_comb begin
    fb     = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    lfsr_d = {fb, lfsr_q[15:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole game scheduler: tick divider, mole spawn/expiry,
// hit scoring and game timer.
module mole_scheduler
  import mole_scheduler_pkg::*;
#(
  parameter int TICK_DIV   = 25000000,
  parameter int MOLE_LIFE  = 3,
  parameter int GAME_TICKS = 60,
  parameter int MAX_ACTIVE = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 hit,
  input  logic [3:0]           hit_pos,
  output logic [NUM_HOLES-1:0] mole_mask,
  output logic [7:0]           score,
  output logic [7:0]           misses,
  output logic [7:0]           escaped,
  output logic [7:0]           time_left,
  output logic                 playing,
  output logic                 game_over
);

  localparam int TW = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
  localparam int LW = (MOLE_LIFE < 2) ? 1 : $clog2(MOLE_LIFE + 1);

  state_e                        state_q, state_d;
  logic [NUM_HOLES-1:0]          mask_q, mask_d;
  logic [7:0]                    score_q, score_d;
  logic [7:0]                    misses_q, misses_d;
  logic [7:0]                    escaped_q, escaped_d;
  logic [7:0]                    time_q, time_d;
  logic [TW-1:0]                 tick_cnt_q, tick_cnt_d;
  logic [NUM_HOLES-1:0][LW-1:0]  life_q, life_d;
  logic                          playing_q, playing_d;
  logic                          over_q, over_d;

  logic [15:0] lfsr;
  logic        tick;
  logic        hit_hole;
  logic        hit_ok;
  logic [3:0]  cand;
  logic [3:0]  n_esc;
  logic [8:0]  esc_sum;

  mole_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr)
  );

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    score_d    = score_q;
    misses_d   = misses_q;
    escaped_d  = escaped_q;
    time_d     = time_q;
    tick_cnt_d = tick_cnt_q;
    life_d     = life_q;
    tick       = 1'b0;
    hit_ok     = 1'b0;
    n_esc      = '0;
    esc_sum    = '0;
    cand       = lfsr[3:0];
    hit_hole   = (hit_pos <= 4'd8);

    unique case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d    = S_PLAY;
          mask_d     = '0;
          score_d    = '0;
          misses_d   = '0;
          escaped_d  = '0;
          time_d     = 8'(GAME_TICKS);
          tick_cnt_d = '0;
          life_d     = '0;
        end
      end
      S_PLAY: begin
        tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

        // Hits are judged against the mask as it stood before this edge.
        if (hit && hit_hole) begin
          if (mask_q[hit_pos]) begin
            hit_ok          = 1'b1;
            mask_d[hit_pos] = 1'b0;
            life_d[hit_pos] = '0;
            score_d         = sat_inc(score_q);
          end else begin
            misses_d = sat_inc(misses_q);
          end
        end else if (hit && hit_pos != NO_HIT) begin
          misses_d = sat_inc(misses_q);
        end

        if (tick) begin
          if (time_q <= 8'd1) begin
            state_d = S_OVER;
            time_d  = '0;
            mask_d  = '0;
            life_d  = '0;
          end else begin
            time_d = time_q - 8'd1;
            for (int i = 0; i < NUM_HOLES; i++) begin
              if (mask_q[i] && !(hit_ok && hit_pos == 4'(i))) begin
                if (life_q[i] == LW'(1)) begin
                  mask_d[i] = 1'b0;
                  life_d[i] = '0;
                  n_esc     = n_esc + 4'd1;
                end else begin
                  life_d[i] = life_q[i] - LW'(1);
                end
              end
            end
            esc_sum   = {1'b0, escaped_q} + {5'b00000, n_esc};
            escaped_d = esc_sum[8] ? 8'hFF : esc_sum[7:0];
            // Pre-tick mask blocks a hole that just expired from respawning.
            if (cand <= 4'd8 && !mask_q[cand] &&
                popcnt9(mask_d) < 4'(MAX_ACTIVE)) begin
              mask_d[cand] = 1'b1;
              life_d[cand] = LW'(MOLE_LIFE);
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    playing_d = (state_d == S_PLAY);
    over_d    = (state_d == S_OVER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mask_q     <= '0;
      score_q    <= '0;
      misses_q   <= '0;
      escaped_q  <= '0;
      time_q     <= '0;
      tick_cnt_q <= '0;
      life_q     <= '0;
      playing_q  <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      score_q    <= score_d;
      misses_q   <= misses_d;
      escaped_q  <= escaped_d;
      time_q     <= time_d;
      tick_cnt_q <= tick_cnt_d;
      life_q     <= life_d;
      playing_q  <= playing_d;
      over_q     <= over_d;
    end
  end

  assign mole_mask = mask_q;
  assign score     = score_q;
  assign misses    = misses_q;
  assign escaped   = escaped_q;
  assign time_left = time_q;
  assign playing   = playing_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler with a 4-cycle tick and 5-tick game.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mole_scheduler;

  logic       clk;
  logic       rst;
  logic       start;
  logic       hit;
  logic [3:0] hit_pos;
  logic [8:0] mole_mask;
  logic [7:0] score;
  logic [7:0] misses;
  logic [7:0] escaped;
  logic [7:0] time_left;
  logic       playing;
  logic       game_over;

  int n_chk;
  int n_pass;
  int h;
  bit ok;

  mole_scheduler #(
    .TICK_DIV   (4),
    .MOLE_LIFE  (3),
    .GAME_TICKS (5),
    .MAX_ACTIVE (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .hit       (hit),
    .hit_pos   (hit_pos),
    .mole_mask (mole_mask),
    .score     (score),
    .misses    (misses),
    .escaped   (escaped),
    .time_left (time_left),
    .playing   (playing),
    .game_over (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic adv(input int n);
    repeat (n) step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_over();
    int k;
    k = 0;
    while (!game_over && k < 40) begin
      step();
      k++;
    end
    if (!game_over) chk("over_timeout", 0, 1);
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_mask"}, mole_mask, 0);
    chk({p, "_score"}, score, 0);
    chk({p, "_misses"}, misses, 0);
    chk({p, "_escaped"}, escaped, 0);
    chk({p, "_time"}, time_left, 0);
    chk({p, "_playing"}, playing, 0);
    chk({p, "_over"}, game_over, 0);
  endtask

  // Starts games until one spawns a mole on its first tick;
  // returns at PLAY cycle 4 with that hole in h.
  task automatic find_spawn(output int hole, output bit found);
    found = 1'b0;
    hole  = 0;
    for (int a = 0; a < 16 && !found; a++) begin
      pulse_start();
      adv(4);
      if (mole_mask != 9'd0) begin
        found = 1'b1;
        for (int i = 0; i < 9; i++) if (mole_mask[i]) hole = i;
      end else begin
        wait_over();
      end
    end
    if (!found) chk("spawn_found", 0, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    rst     = 1'b1;
    start   = 1'b0;
    hit     = 1'b0;
    hit_pos = 4'hF;
    adv(2);
    rst = 1'b0;
    step();
    chk_reset_vals("rst");

    hit = 1'b1; hit_pos = 4'd11;
    step();
    hit = 1'b0;
    chk("idle_hit_misses", misses, 0);

    // Game A: misses, ignored start, occupancy cap, timeout.
    pulse_start();
    chk("a_playing", playing, 1);
    chk("a_time", time_left, 5);
    chk("a_score", score, 0);
    chk("a_misses0", misses, 0);
    chk("a_escaped", escaped, 0);
    chk("a_mask", mole_mask, 0);
    hit = 1'b1; hit_pos = 4'd4;
    step();
    hit_pos = 4'd11;
    step();
    hit_pos = 4'hF;
    step();
    hit = 1'b0;
    chk("a_misses2", misses, 2);
    chk("a_score0", score, 0);
    for (int c = 3; c < 20; c++) begin
      chk("a_max_active", int'($countones(mole_mask) <= 2), 1);
      if (c == 19) begin
        chk("a_time_last", time_left, 1);
        chk("a_playing_last", playing, 1);
      end
      if (c == 9) start = 1'b1;
      step();
      start = 1'b0;
      if (c == 9) begin
        chk("a_restart_time", time_left, 3);
        chk("a_restart_play", playing, 1);
      end
    end
    chk("a_over", game_over, 1);
    chk("a_over_time", time_left, 0);
    chk("a_over_mask", mole_mask, 0);
    chk("a_over_playing", playing, 0);
    hit = 1'b1; hit_pos = 4'd4;
    step();
    hit = 1'b0;
    chk("over_hit_misses", misses, 2);
    chk("over_hit_score", score, 0);

    // Game B: first-tick mole escapes on its third tick.
    find_spawn(h, ok);
    if (ok) begin
      adv(11);
      chk("b_vis_c15", mole_mask[h], 1);
      chk("b_esc_c15", escaped, 0);
      step();
      chk("b_gone_c16", mole_mask[h], 0);
      chk("b_esc_c16", escaped, 1);
      wait_over();
      chk("b_esc_final", escaped, 1);
      chk("b_mask_final", mole_mask, 0);
    end

    // Game C: hit lands on the expiry tick.
    find_spawn(h, ok);
    if (ok) begin
      adv(11);
      hit = 1'b1; hit_pos = 4'(h);
      step();
      hit = 1'b0;
      chk("c_gone", mole_mask[h], 0);
      chk("c_score", score, 1);
      chk("c_escaped", escaped, 0);
      chk("c_misses", misses, 0);
      wait_over();
      chk("c_esc_final", escaped, 0);
    end

    // Game D: plain hit, repeat on emptied hole, then reset mid-game.
    find_spawn(h, ok);
    if (ok) begin
      step();
      hit = 1'b1; hit_pos = 4'(h);
      step();
      hit = 1'b0;
      chk("d_gone", mole_mask[h], 0);
      chk("d_score", score, 1);
      chk("d_misses0", misses, 0);
      step();
      hit = 1'b1; hit_pos = 4'(h);
      step();
      hit = 1'b0;
      chk("d_misses1", misses, 1);
      chk("d_score1", score, 1);
      adv(3);
      rst = 1'b1; start = 1'b1; hit = 1'b1; hit_pos = 4'd11;
      step();
      rst = 1'b0; start = 1'b0; hit = 1'b0;
      chk_reset_vals("midrst");
    end

    pulse_start();
    chk("e_playing", playing, 1);
    chk("e_time", time_left, 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mole_scheduler.md
MOLE_SCHEDULER -- requirements
Module: mole_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 25000000, clk cycles per game tick.
REQ-002 Parameter MOLE_LIFE, default 3, ticks a spawned mole stays visible.
REQ-003 Parameter GAME_TICKS, default 60, ticks per game; range 1..255.
REQ-004 Parameter MAX_ACTIVE, default 3, maximum simultaneously visible moles; range 1..9.
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 start  input  1  single-cycle pulse requesting a new game.
REQ-008 hit  input  1  single-cycle pulse: a key press occurred this cycle.
REQ-009 hit_pos  input  4  hole index 0..8 of the press; 9..14 are non-hole keys; 15 means no press.
REQ-010 mole_mask  output  9  bit i high = mole visible in hole i.
REQ-011 score  output  8  successful hits, saturating.
REQ-012 misses  output  8  presses on empty holes or non-hole keys, saturating.
REQ-013 escaped  output  8  moles that expired unhit, saturating.
REQ-014 time_left  output  8  remaining game ticks.
REQ-015 playing  output  1  high in PLAY state.
REQ-016 game_over  output  1  high in OVER state.

Function
REQ-017 FSM states IDLE, PLAY, OVER; IDLE->PLAY and OVER->PLAY on start; PLAY->OVER when time_left reaches 0; start in PLAY is ignored.
REQ-018 On entry to PLAY: mole_mask, score, misses, escaped, tick counter, life counters cleared; time_left loaded with GAME_TICKS.
REQ-019 Tick: counter runs 0..TICK_DIV-1 only in PLAY; tick pulse asserted in the cycle the counter equals TICK_DIV-1, then wraps to 0.
REQ-020 Each hole owns a life counter loaded with MOLE_LIFE on spawn and decremented on every tick; on a tick where it equals 1 the mole expires: mask bit cleared, escaped incremented.
REQ-021 Spawn evaluated only on ticks, after expiry: candidate = lfsr[3:0]; spawn iff candidate <= 8, candidate hole empty in pre-tick mask, and post-expiry visible count < MAX_ACTIVE; at most one spawn per tick.
REQ-022 A hole that expires on a tick cannot respawn on that same tick.
REQ-023 Hit handling in PLAY when hit=1: hit_pos 0..8 with mask bit set -> bit cleared, score+1; hit_pos 0..8 with bit clear, or hit_pos 9..14 -> misses+1; hit_pos 15 -> no effect.
REQ-024 Hit effects visible one cycle after the hit cycle (registered); no combinational input-to-output path.
REQ-025 Simultaneous hit and expiry on the same hole: hit wins (score+1, escaped unchanged).
REQ-026 Simultaneous hit and spawn on the same hole: hit judged on pre-cycle mask (miss), spawn takes effect.
REQ-027 time_left decrements on each tick; on the tick where time_left equals 1 it becomes 0, state becomes OVER, mole_mask cleared, no expiries counted for cleared moles.
REQ-028 In IDLE and OVER, hit is ignored; score, misses, escaped, time_left hold.
REQ-029 All counters saturate at 255; no wrap.
REQ-030 LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1, advances every clk cycle in all states.

Reset
REQ-031 rst forces state IDLE, mole_mask 0, score 0, misses 0, escaped 0, time_left 0, playing 0, game_over 0, tick counter 0, life counters 0, LFSR 16'hACE1.
REQ-032 rst asserted mid-game has priority over start, hit and tick in the same cycle.

Structure
REQ-033 Shared package holds the state enumeration, NUM_HOLES=9, NO_HIT=4'hF and the LFSR seed.
REQ-034 LFSR is a separate sub-module mole_lfsr (clk, rst, 16-bit value out); all else in mole_scheduler.

Verification (TICK_DIV=4, MOLE_LIFE=3, GAME_TICKS=5, MAX_ACTIVE=2)
REQ-035 rst then start -> playing=1 next cycle, time_left=5, all counters 0; after 20 cycles game_over=1, time_left=0, mole_mask=0.
REQ-036 Force visible mole in hole 4; hit=1, hit_pos=4 -> next cycle bit 4 clear, score=1, misses=0.
REQ-037 hit_pos=4 on empty hole, then hit_pos=11, then hit_pos=15 with hit=0 -> misses=2, score=0.
REQ-038 Mole left unhit for 3 ticks (12 cycles) -> bit clears on third tick, escaped=1; same with hit on expiry cycle -> score=1, escaped=0.
REQ-039 Run full game with no hits -> popcount(mole_mask) never exceeds 2 in any cycle; start during PLAY changes nothing.
REQ-040 rst asserted mid-game with hit=1 and start=1 -> all outputs equal reset values next cycle.
